mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Shares the single-port synchronous RAM between two requesters: instruction fetch (read-only) and data load/store.
- Sits between the multicycle controller/datapath and the RAM.
- Issues at most one RAM access per cycle and tracks one outstanding read.
- Returns read data to whichever requester issued the read.

Parameters:
- WIDTH, 32, data width in bits; must be a multiple of 8.
- ADDR_WIDTH, 10, RAM word-address width.
- RAM_LATENCY, 1, cycles from the RAM address cycle to valid ram_rdata; must be ≥1.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- if_req  in  1  fetch read request
- if_addr  in  ADDR_WIDTH  fetch word address
- if_gnt  out  1  fetch request accepted this cycle
- if_rvalid  out  1  if_rdata valid this cycle
- if_rdata  out  WIDTH  fetch read data
- d_req  in  1  data request
- d_we  in  1  1 = store, 0 = load
- d_be  in  WIDTH/8  store byte enables
- d_addr  in  ADDR_WIDTH  data word address
- d_wdata  in  WIDTH  store data
- d_gnt  out  1  data request accepted this cycle
- d_rvalid  out  1  d_rdata valid this cycle
- d_rdata  out  WIDTH  load data
- ram_en  out  1  RAM access strobe
- ram_we  out  1  RAM write strobe
- ram_be  out  WIDTH/8  RAM byte enables
- ram_addr  out  ADDR_WIDTH  RAM address
- ram_wdata  out  WIDTH  RAM write data
- ram_rdata  in  WIDTH  RAM read data

Behaviour:
- Reset:
  - State IDLE, latency counter 0, owner FETCH, last-grant FETCH.
  - All outputs 0 while rst is high.
- States:
  - IDLE: grants allowed.
  - BUSY: read outstanding; no grants except in the return cycle.
- Grant:
  - Combinational (Mealy) from req in IDLE, or in the BUSY return cycle.
  - Exactly one gnt at a time.
  - Default priority: data over fetch. The controller is stalled in the memory state, while fetch only occurs in FETCH.
- Grant cycle drives the RAM:
  - ram_en=1, and ram_addr from the winner.
  - Store: ram_we=1, ram_be=d_be, ram_wdata=d_wdata.
  - Reads: ram_we=0 and ram_be all-ones.
  - ram_wdata=0 when not storing.
- Store: completes in the grant cycle. No rvalid, no state change.
- Read:
  - Owner latched; counter loaded with RAM_LATENCY; go to BUSY.
  - BUSY decrements the counter each cycle.
  - When the counter is 1, the return cycle: owner's rvalid=1, rdata=ram_rdata, and the next state is IDLE.
- Back-to-back: a new grant is permitted in the return cycle. Peak rate is one read per RAM_LATENCY cycles and one store per cycle.
- rdata outputs are 0 whenever the matching rvalid is 0. The non-owner's rvalid is never asserted.
- Requester rules:
  - Hold req/addr/data stable until gnt.
  - Dropping req before gnt is legal; nothing is issued.
- Reset mid-read: the outstanding read is discarded and no rvalid is produced afterward.
- Widths:
  - Counter width is $clog2(RAM_LATENCY+1).
  - No address arithmetic; addresses pass through unmodified.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined: round-robin. On simultaneous if_req and d_req, the port not granted most recently wins. last-grant updates on every grant, stores included.
- Undefined: fixed data-over-fetch priority. last-grant register not instantiated.

Decomposition:
- Shared package rv32i_mem_pkg:
  - mem_owner_t enum {FETCH, DATA}.
  - arb_state_t enum {IDLE, BUSY}.
- No sub-module. A small latency counter is kept inline.

Test Plan:
- Fetch read: with RAM_LATENCY=1, if_req=1, if_addr=0x004, RAM word 4 = 0x00A00093 → if_gnt same cycle, ram_en=1, ram_addr=0x004, ram_we=0. One cycle later if_rvalid=1, if_rdata=0x00A00093, d_rvalid=0.
- Store: d_req=1, d_we=1, d_be=4'b0011, d_addr=0x010, d_wdata=0xDEADBEEF → d_gnt, ram_we=1, ram_be=0011 same cycle. A later load from 0x010 returns 0x0000BEEF (RAM preloaded 0).
- Contention: if_req and d_req both 1 in IDLE → d_gnt=1, if_gnt=0.
  - Without MEM_ARB_RR_EN: repeated ties keep granting data.
  - With MEM_ARB_RR_EN: after one data grant, the next tie grants fetch.
- Latency: RAM_LATENCY=3, d_req load at cycle N → rvalid at N+3. A request held at N+1 and N+2 gets no gnt. A request at N+3 gets gnt at N+3 (back-to-back).
- Reset mid-read: load granted at cycle N, rst pulsed at N+1 (RAM_LATENCY=2) → no rvalid ever, state IDLE, all outputs 0 during rst, next request granted normally.
- Withdrawn request: if_req high for 1 cycle while BUSY, then low → no if_gnt and no RAM access issued for it.

Source files
------------

// File: rtl/rv32i_mem_pkg.sv
// Shared types for the instruction/data memory arbiter: who owns the
// outstanding read and the arbiter's two-state controller.
package rv32i_mem_pkg;

  typedef enum logic {
    FETCH = 1'b0,
    DATA  = 1'b1
  } mem_owner_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates the single-port RAM between instruction fetch and data load/store,
// tracking one outstanding read. Define MEM_ARB_RR_EN for round-robin on ties.
import rv32i_mem_pkg::*;

module mem_arbiter #(
  parameter int WIDTH       = 32,
  parameter int ADDR_WIDTH  = 10,
  parameter int RAM_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  output logic [WIDTH-1:0]      if_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [WIDTH/8-1:0]    d_be,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [WIDTH-1:0]      d_wdata,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [WIDTH-1:0]      d_rdata,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [WIDTH/8-1:0]    ram_be,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [WIDTH-1:0]      ram_wdata,
  input  logic [WIDTH-1:0]      ram_rdata
);

  localparam int CNT_W = $clog2(RAM_LATENCY + 1);

  arb_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  mem_owner_t       owner_q, owner_d;
  mem_owner_t       winner;
  logic             retCycle;
  logic             canGrant;
  logic             readGrant;

  // The return cycle doubles as a grant slot so reads can go back-to-back.
  assign retCycle  = (state_q == BUSY) && (cnt_q == CNT_W'(1));
  assign canGrant  = !rst && ((state_q == IDLE) || retCycle);
  assign d_gnt     = canGrant && d_req && (winner == DATA);
  assign if_gnt    = canGrant && if_req && (winner == FETCH);
  assign readGrant = if_gnt || (d_gnt && !d_we);

`ifdef MEM_ARB_RR_EN
  mem_owner_t last_q, last_d;

  always_comb begin
    if (if_req && d_req) begin
      winner = (last_q == DATA) ? FETCH : DATA;
    end else begin
      winner = d_req ? DATA : FETCH;
    end
  end

  always_comb begin
    last_d = last_q;
    if (d_gnt) begin
      last_d = DATA;
    end else if (if_gnt) begin
      last_d = FETCH;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= FETCH;
    end else begin
      last_q <= last_d;
    end
  end
`else
  // Data wins ties: the controller is stalled waiting on it, fetch is not.
  assign winner = d_req ? DATA : FETCH;
`endif

  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_be    = '0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (d_gnt) begin
      ram_en   = 1'b1;
      ram_addr = d_addr;
      if (d_we) begin
        ram_we    = 1'b1;
        ram_be    = d_be;
        ram_wdata = d_wdata;
      end else begin
        ram_be = '1;
      end
    end else if (if_gnt) begin
      ram_en   = 1'b1;
      ram_addr = if_addr;
      ram_be   = '1;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    owner_d = owner_q;
    if (state_q == BUSY) begin
      cnt_d = cnt_q - CNT_W'(1);
      if (retCycle) begin
        state_d = IDLE;
      end
    end
    if (readGrant) begin
      state_d = BUSY;
      cnt_d   = CNT_W'(RAM_LATENCY);
      owner_d = d_gnt ? DATA : FETCH;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      owner_q <= FETCH;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
    end
  end

  // Read data is only routed to the requester that owns the outstanding read.
  assign if_rvalid = !rst && retCycle && (owner_q == FETCH);
  assign d_rvalid  = !rst && retCycle && (owner_q == DATA);
  assign if_rdata  = if_rvalid ? ram_rdata : '0;
  assign d_rdata   = d_rvalid ? ram_rdata : '0;

endmodule
